ntt_core_ram_ctrl: RTL and testbench

Ping-pong controller for one core's 2×HEIGHT×60-bit NTT coefficient RAM. It treats the RAM's two select columns as two banks. An upstream valid/ready stream fills one bank while the other bank is drained, in address order, to a downstream valid/ready stream. The block sits between the stage input and output streams and the core RAM, and it hides the RAM's one-cycle registered read latency behind a small output buffer.

---
 rtl/ntt_core_ram_ctrl.sv | 146 ++++++++++++++
 tb/tb_ntt_core_ram_ctrl.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/ntt_core_ram_ctrl.sv
// rtl/ntt_core_ram_ctrl.sv - ping-pong fill/drain controller for one NTT core coefficient RAM
// Optional: define NTT_CTRL_BITREV_EN to drain each bank in bit-reversed address order.
module ntt_core_ram_ctrl #(
    parameter int LOG_N          = 12,
    parameter int LOG_CORE_COUNT = 5,
    localparam int AW            = LOG_N - (LOG_CORE_COUNT + 2),
    localparam int HEIGHT        = 1 << AW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [59:0]   in_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [59:0]   out_data,
    output logic          ram_write_enable,
    output logic          ram_write_select,
    output logic [AW-1:0] ram_write_address,
    output logic [59:0]   ram_data_in,
    output logic          ram_read_select,
    output logic [AW-1:0] ram_read_address,
    input  logic [59:0]   ram_data_out,
    output logic          frame_done,
    output logic [1:0]    bank_full
);
    typedef enum logic [1:0] {S_EMPTY, S_FILLING, S_FULL, S_DRAINING} bank_state_e;

    bank_state_e   state_q [2];
    bank_state_e   state_d [2];
    logic          wbank_q, wbank_d, rbank_q, rbank_d;
    logic [AW-1:0] wcnt_q, wcnt_d;
    logic [AW:0]   rcnt_q, rcnt_d;
    logic [1:0]    occ_q, occ_d;
    logic          inflight_q, inflight_d;
    logic [59:0]   fifo_q [2];
    logic [59:0]   fifo_d [2];
    logic          head_q, head_d, tail_q, tail_d;
    logic [1:0]    bank_full_q, bank_full_d;
    logic          frame_done_q, frame_done_d;

    logic          wr_fire, rd_active, pop, issue, drain_done;
    logic [AW-1:0] raddr;

`ifdef NTT_CTRL_BITREV_EN
    always_comb begin
        raddr = '0;
        for (int i = 0; i < AW; i++) raddr[i] = rcnt_q[AW-1-i];
    end
`else
    assign raddr = rcnt_q[AW-1:0];
`endif

    assign in_ready  = !rst && (state_q[wbank_q] == S_EMPTY || state_q[wbank_q] == S_FILLING);
    assign wr_fire   = in_valid && in_ready;
    assign out_valid = (occ_q != 2'd0);
    assign pop       = out_valid && out_ready;
    assign rd_active = (state_q[rbank_q] == S_FULL) || (state_q[rbank_q] == S_DRAINING);
    // A same-cycle pop frees a slot, which is what lets the drain sustain one word per cycle
    assign issue      = rd_active && (rcnt_q < (AW+1)'(HEIGHT))
                        && ((3'(occ_q) + 3'(inflight_q)) < (pop ? 3'd3 : 3'd2));
    assign drain_done = rd_active && (rcnt_q == (AW+1)'(HEIGHT)) && !inflight_q
                        && (occ_q == 2'd0 || (occ_q == 2'd1 && pop));

    always_comb begin
        state_d      = state_q;
        wbank_d      = wbank_q;
        rbank_d      = rbank_q;
        wcnt_d       = wcnt_q;
        rcnt_d       = rcnt_q;
        fifo_d       = fifo_q;
        head_d       = head_q;
        tail_d       = tail_q;
        inflight_d   = issue;
        frame_done_d = drain_done;
        if (wr_fire) begin
            wcnt_d = wcnt_q + 1'b1;
            if (wcnt_q == AW'(HEIGHT - 1)) begin
                state_d[wbank_q] = S_FULL;
                wbank_d          = !wbank_q;
            end else begin
                state_d[wbank_q] = S_FILLING;
            end
        end
        if (issue) begin
            rcnt_d           = rcnt_q + 1'b1;
            state_d[rbank_q] = S_DRAINING;
        end
        if (drain_done) begin
            state_d[rbank_q] = S_EMPTY;
            rbank_d          = !rbank_q;
            rcnt_d           = '0;
        end
        // RAM read data is registered, so the word for last cycle's issue arrives now
        if (inflight_q) begin
            fifo_d[tail_q] = ram_data_out;
            tail_d         = !tail_q;
        end
        if (pop) head_d = !head_q;
        occ_d = occ_q + {1'b0, inflight_q} - {1'b0, pop};
        for (int b = 0; b < 2; b++)
            bank_full_d[b] = (state_d[b] == S_FULL) || (state_d[b] == S_DRAINING);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q[0]   <= S_EMPTY;
            state_q[1]   <= S_EMPTY;
            wbank_q      <= 1'b0;
            rbank_q      <= 1'b0;
            wcnt_q       <= '0;
            rcnt_q       <= '0;
            occ_q        <= 2'd0;
            inflight_q   <= 1'b0;
            fifo_q[0]    <= '0;
            fifo_q[1]    <= '0;
            head_q       <= 1'b0;
            tail_q       <= 1'b0;
            bank_full_q  <= 2'b00;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            wbank_q      <= wbank_d;
            rbank_q      <= rbank_d;
            wcnt_q       <= wcnt_d;
            rcnt_q       <= rcnt_d;
            occ_q        <= occ_d;
            inflight_q   <= inflight_d;
            fifo_q       <= fifo_d;
            head_q       <= head_d;
            tail_q       <= tail_d;
            bank_full_q  <= bank_full_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign ram_write_enable  = wr_fire;
    assign ram_write_select  = wbank_q;
    assign ram_write_address = wcnt_q;
    assign ram_data_in       = in_data;
    assign ram_read_select   = rbank_q;
    assign ram_read_address  = raddr;
    assign out_data          = fifo_q[head_q];
    assign frame_done        = frame_done_q;
    assign bank_full         = bank_full_q;
endmodule

// File: tb/tb_ntt_core_ram_ctrl.sv
// tb/tb_ntt_core_ram_ctrl.sv - self-checking bench for ntt_core_ram_ctrl with a RAM model and frame-level reference
module tb_ntt_core_ram_ctrl;
    localparam int AW = 5;
    localparam int H  = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid, in_ready, out_valid, out_ready;
    logic [59:0]   in_data, out_data, ram_data_in, ram_data_out;
    logic          ram_write_enable, ram_write_select, ram_read_select, frame_done;
    logic [AW-1:0] ram_write_address, ram_read_address;
    logic [1:0]    bank_full;

    logic [59:0]   mem [2][H];
    logic [59:0]   exp_q [$];
    logic [59:0]   frame_buf [H];
    int            n_cmp = 0;
    int            n_err = 0;
    int            g_frames = 0;
    int            ndone;

    ntt_core_ram_ctrl dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .ram_write_enable(ram_write_enable), .ram_write_select(ram_write_select),
        .ram_write_address(ram_write_address), .ram_data_in(ram_data_in),
        .ram_read_select(ram_read_select), .ram_read_address(ram_read_address),
        .ram_data_out(ram_data_out), .frame_done(frame_done), .bank_full(bank_full)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (ram_write_enable) mem[ram_write_select][ram_write_address] <= ram_data_in;
        ram_data_out <= mem[ram_read_select][ram_read_address];
    end

    function automatic int raddr_of(input int i);
        int r;
`ifdef NTT_CTRL_BITREV_EN
        r = 0;
        for (int b = 0; b < AW; b++) if (((i >> b) & 1) != 0) r = r | (1 << (AW - 1 - b));
`else
        r = i;
`endif
        return r;
    endfunction

    task automatic run_traffic(input int nwords, input logic [59:0] base, input int vpct, input int rmode,
                               input bit lat_chk, input bit bp_chk, input bit rdy_chk, input int stop_at);
        int sent, got, cycles, nlast, in_low;
        bit first_seen, bp_seen;
        sent = 0; got = 0; cycles = 0; nlast = -1; in_low = 0; first_seen = 0; bp_seen = 0; ndone = 0;
        while ((sent < nwords || got < stop_at) && cycles < 4000) begin
            @(negedge clk);
            in_valid = (sent < nwords) && ($urandom_range(99) < vpct);
            in_data  = base + 60'(sent);
            case (rmode)
                0: out_ready = 1'b1;
                1: out_ready = cycles[0];
                2: out_ready = (cycles < 60) ? cycles[0] : ((cycles < 100) ? 1'b0 : 1'b1);
                default: out_ready = 1'($urandom_range(1));
            endcase
            #1;
            if (frame_done) ndone++;
            if (rdy_chk && sent < nwords && !in_ready) in_low++;
            if (bp_chk && sent == 2*H && !bp_seen) begin
                bp_seen = 1; n_cmp++;
                if (in_ready !== 1'b0) begin n_err++; $display("FAIL bp_in_ready: got %b expected 0", in_ready); end
            end
            if (lat_chk && nlast >= 0 && cycles == nlast + 1) begin
                n_cmp++;
                if (bank_full !== 2'b01) begin n_err++; $display("FAIL bank_full_after_fill: got %b expected 01", bank_full); end
            end
            if (lat_chk && out_valid && !first_seen) begin
                first_seen = 1; n_cmp++;
                if (cycles != nlast + 3) begin n_err++; $display("FAIL first_out_latency: got cycle %0d expected %0d", cycles, nlast + 3); end
            end
            if (in_valid && in_ready) begin
                n_cmp++;
                if (ram_write_enable !== 1'b1 || ram_write_address !== AW'(sent % H) || ram_write_select !== 1'(g_frames % 2)) begin
                    n_err++;
                    $display("FAIL write_port: got we=%b sel=%b addr=%0d expected we=1 sel=%0d addr=%0d",
                             ram_write_enable, ram_write_select, ram_write_address, g_frames % 2, sent % H);
                end
                frame_buf[sent % H] = in_data;
                sent++;
                if (sent % H == 0) begin
                    for (int i = 0; i < H; i++) exp_q.push_back(frame_buf[raddr_of(i)]);
                    g_frames++;
                    if (sent == H) nlast = cycles;
                end
            end else if (!in_valid) begin
                n_cmp++;
                if (ram_write_enable !== 1'b0) begin n_err++; $display("FAIL idle_write: got we=%b expected 0", ram_write_enable); end
            end
            if (out_valid) begin
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_err++; $display("FAIL unexpected_out: got %0h expected no word", out_data);
                end else if (out_data !== exp_q[0]) begin
                    n_err++; $display("FAIL out_data: got %0h expected %0h (word %0d)", out_data, exp_q[0], got);
                end
                if (out_ready && exp_q.size() != 0) begin void'(exp_q.pop_front()); got++; end
            end
            cycles++;
        end
        if (cycles >= 4000) begin
            n_cmp++; n_err++;
            $display("FAIL timeout: got sent=%0d out=%0d expected %0d/%0d", sent, got, nwords, stop_at);
        end
        if (rdy_chk) begin
            n_cmp++;
            if (in_low != 0) begin n_err++; $display("FAIL in_ready_single: got %0d low cycles expected 0", in_low); end
        end
        if (stop_at == nwords) begin
            repeat (4) begin
                @(negedge clk); #1;
                if (frame_done) ndone++;
            end
            n_cmp++;
            if (ndone != nwords / H) begin n_err++; $display("FAIL frame_done_count: got %0d expected %0d", ndone, nwords / H); end
            n_cmp++;
            if (out_valid !== 1'b0 || bank_full !== 2'b00 || exp_q.size() != 0) begin
                n_err++; $display("FAIL idle_after_drain: got valid=%b full=%b left=%0d expected 0 00 0", out_valid, bank_full, exp_q.size());
            end
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        n_cmp++;
        if (in_ready !== 1'b0 || out_valid !== 1'b0 || frame_done !== 1'b0 || bank_full !== 2'b00 ||
            ram_write_enable !== 1'b0 || ram_write_select !== 1'b0 || ram_read_select !== 1'b0 ||
            ram_write_address !== '0 || ram_read_address !== '0) begin
            n_err++;
            $display("FAIL %s: got rdy=%b ov=%b fd=%b full=%b we=%b wsel=%b rsel=%b wa=%0d ra=%0d expected all 0",
                     tag, in_ready, out_valid, frame_done, bank_full, ram_write_enable, ram_write_select,
                     ram_read_select, ram_write_address, ram_read_address);
        end
    endtask

    task automatic release_reset();
        @(negedge clk);
        rst = 1'b0; in_valid = 1'b0;
        #1;
        n_cmp++;
        if (in_ready !== 1'b1) begin n_err++; $display("FAIL in_ready_after_reset: got %b expected 1", in_ready); end
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b1; in_data = 60'h5; out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #2;
        check_reset_outputs("reset_state");
        g_frames = 0; exp_q.delete();
        release_reset();
    endtask

    task automatic test_single_frame();
        run_traffic(H, 60'd0, 100, 0, 1'b1, 1'b0, 1'b1, H);
    endtask

    task automatic test_back_to_back();
        run_traffic(3*H, 60'd0, 100, 0, 1'b0, 1'b0, 1'b0, 3*H);
    endtask

    task automatic test_backpressure();
        run_traffic(3*H, 60'd1000, 100, 2, 1'b0, 1'b1, 1'b0, 3*H);
    endtask

    task automatic test_gaps();
        run_traffic(H, 60'd0, 50, 0, 1'b0, 1'b0, 1'b0, H);
    endtask

    task automatic test_random();
        logic [59:0] base;
        base = {28'($urandom), 32'($urandom)};
        run_traffic(2*H, base, 70, 3, 1'b0, 1'b0, 1'b0, 2*H);
    endtask

    task automatic test_reset_mid_drain();
        run_traffic(H, 60'd0, 100, 0, 1'b0, 1'b0, 1'b0, 10);
        @(negedge clk);
        out_ready = 1'b0; in_valid = 1'b1;
        #1;
        n_cmp++;
        if (out_valid !== 1'b1 || out_data !== 60'd10) begin
            n_err++; $display("FAIL pending_word: got valid=%b data=%0h expected 1 a", out_valid, out_data);
        end
        #2 rst = 1'b1;
        #1 check_reset_outputs("async_reset_mid_drain");
        @(negedge clk); #1;
        check_reset_outputs("reset_held");
        g_frames = 0; exp_q.delete();
        release_reset();
        run_traffic(H, 60'd100, 100, 0, 1'b0, 1'b0, 1'b0, H);
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_back_to_back();
        test_backpressure();
        test_gaps();
        test_random();
        test_reset_mid_drain();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
